multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control sequencer for the multi-cycle LEGv8 datapath. Steps each instruction through fetch, decode, execute, memory and write-back states. Drives the datapath strobes and mux selects, and produces the 2-bit ALUop consumed by the ALU control decoder. Shares the single ALU between PC increment, branch-target and data operations by time-multiplexing it across states.

## Interface
Parameters: none.
- CLK  in  1  clock; all state changes on rising edge
- Reset_L  in  1  synchronous, active-low reset
- Opcode  in  11  instruction bits 31:21 from the instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory access complete this cycle
- PCWrite  out  1  load PC
- PCSrc  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
- IRWrite  out  1  load instruction register
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write
- MemtoReg  out  1  write-back data: 1 = memory, 0 = ALUOut
- Reg2Loc  out  1  read port 2 address: 1 = Rt (bits 4:0), 0 = Rm
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted branch offset
- ALUop  out  2  00 add, 01 pass B, 10 decode Opcode
- State  out  3  current state (debug)
- Illegal  out  1  sticky illegal-opcode flag

## Operation
States: FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WBACK=4, BRCH=5, HALT=6.
- FETCH:
  - MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUop=00.
  - While MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut).
  - Reg2Loc=1 for STUR/CBZ.
  - Classify Opcode and latch the class into a register.
- Classes and next state from DECODE:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LSL 11010011011): go to EXEC.
  - ORRI (1011001000x): go to EXEC.
  - LDUR 11111000010, STUR 11111000000: go to EXEC.
  - CBZ (10110100xxx), B (000101xxxxx): go to BRCH.
  - Anything else: see Configuration.
- EXEC: ALUSrcA=1.
  - R-type: ALUSrcB=00, ALUop=10, then WBACK.
  - ORRI: ALUSrcB=10, ALUop=10, then WBACK.
  - LDUR/STUR: ALUSrcB=10, ALUop=00, then MEMACC.
- MEMACC:
  - LDUR drives MemRead=1; STUR drives MemWrite=1.
  - Strobe held until MemReady=1.
  - Then LDUR goes to WBACK, STUR goes to FETCH.
- WBACK: RegWrite=1, MemtoReg=1 only for LDUR, then FETCH.
- BRCH:
  - ALUSrcA=1, ALUSrcB=00, ALUop=01, Reg2Loc=1, PCSrc=1.
  - PCWrite = B | (CBZ & Zero).
  - Then FETCH.
- HALT: all strobes 0, remains until reset.
- Outputs are combinational from state plus latched class. Any output not listed for a state is 0.

## Timing
- Reset:
  - Reset_L=0 at a rising edge: state becomes FETCH, latched class becomes R-type, Illegal becomes 0.
  - While Reset_L=0, all strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) are forced to 0.
  - Reset mid-instruction abandons the instruction with no further writes.
- Cycle counts with MemReady=1 every cycle:
  - R-type/ORRI: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ/B: 3 cycles.
- Each MemReady=0 cycle in FETCH/MEMACC adds one cycle. Strobes stay stable during the stall.
- MemReady is ignored outside FETCH/MEMACC.
- Zero is sampled only in BRCH.
- Opcode is sampled only in DECODE. Later states use the latched class, so IR changes after DECODE are ignored.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an unrecognized Opcode in DECODE goes to HALT and sets Illegal=1. Illegal stays set until reset.
- CTRL_ILLEGAL_TRAP_EN undefined: an unrecognized Opcode is a NOP (DECODE goes to FETCH). Illegal is tied to 0 and HALT is unreachable.

## Structure
- Package ctrl_pkg contains:
  - state encoding constants;
  - opcode constants and masks;
  - ALUop encodings (00/01/10);
  - ALUSrcB encodings;
  - instruction-class encoding.
- Sub-module insn_classify: combinational Opcode-to-class decoder, instantiated once and used in DECODE.

## Test plan
- ADD, MemReady=1: state sequence 0,1,2,4,0. EXEC shows ALUop=10, ALUSrcB=00. RegWrite=1 only in WBACK.
- LDUR with MemReady=0 for 2 MEMACC cycles: MemRead held for 3 cycles, then WBACK with MemtoReg=1. Total 7 cycles.
- CBZ: Zero=1 gives PCWrite=1, PCSrc=1 in BRCH. Zero=0 gives PCWrite=0. Both take 3 cycles.
- Reset_L=0 asserted in MEMACC of STUR: MemWrite drops to 0 the same cycle. State is 0 after the edge.
- Opcode 11'h7FF with the macro defined: HALT and Illegal=1 persist until reset. Without the macro: returns to FETCH with no writes.
- FETCH with MemReady=0 for 3 cycles: IRWrite/PCWrite stay 0 and MemRead stays 1. Both strobes pulse for exactly one cycle when MemReady=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle LEGv8 control sequencer.
// State encoding, opcode match values/masks, ALUop and ALUSrcB select codes,
// and the instruction-class encoding latched in DECODE.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WBACK  = 3'd4,
        S_BRCH   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_ORRI    = 3'd1,
        CL_LDUR    = 3'd2,
        CL_STUR    = 3'd3,
        CL_CBZ     = 3'd4,
        CL_B       = 3'd5,
        CL_ILLEGAL = 3'd6
    } insn_class_t;

    // Exact-match opcodes (instruction bits 31:21)
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Masked opcodes: bits cleared in the mask are don't-care
    localparam logic [10:0] OP_ORRI   = 11'b10110010000;
    localparam logic [10:0] MASK_ORRI = 11'b11111111110;
    localparam logic [10:0] OP_CBZ    = 11'b10110100000;
    localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
    localparam logic [10:0] OP_B      = 11'b00010100000;
    localparam logic [10:0] MASK_B    = 11'b11111100000;

    // ALUop codes consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNC  = 2'b10;

    // ALU B-operand select codes
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return (op & mask) == val;
    endfunction

endpackage

// File: rtl/insn_classify.sv
// insn_classify: combinational decoder from Opcode (IR bits 31:21) to
// instruction class. Unrecognized encodings map to CL_ILLEGAL.
module insn_classify
    import ctrl_pkg::*;
(
    input  logic [10:0]  opcode,
    output insn_class_t  insn_class
);

    // Priority decode of the supported opcode set
    always_comb begin
        insn_class = CL_ILLEGAL;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND ||
            opcode == OP_ORR || opcode == OP_LSL)
            insn_class = CL_RTYPE;
        else if (op_match(opcode, OP_ORRI, MASK_ORRI))
            insn_class = CL_ORRI;
        else if (opcode == OP_LDUR)
            insn_class = CL_LDUR;
        else if (opcode == OP_STUR)
            insn_class = CL_STUR;
        else if (op_match(opcode, OP_CBZ, MASK_CBZ))
            insn_class = CL_CBZ;
        else if (op_match(opcode, OP_B, MASK_B))
            insn_class = CL_B;
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencer for the multi-cycle LEGv8 datapath.
// Steps FETCH -> DECODE -> EXEC/BRCH -> MEMACC -> WBACK, time-sharing the
// single ALU. Outputs are decoded from state plus the class latched in DECODE.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unrecognized opcode -> HALT,
// sticky Illegal). Without it, unrecognized opcodes act as NOPs.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUop,
    output logic [2:0]  State,
    output logic        Illegal
);

    state_t      state_q;
    state_t      state_d;
    insn_class_t class_q;
    insn_class_t decoded;

    insn_classify u_classify (
        .opcode     (Opcode),
        .insn_class (decoded)
    );

    assign State = state_q;

    // State register and class latch; Opcode is only captured in DECODE
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q <= S_FETCH;
            class_q <= CL_RTYPE;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                class_q <= decoded;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal flag, set when DECODE traps to HALT
    always_ff @(posedge CLK) begin
        if (!Reset_L)
            illegal_q <= 1'b0;
        else if (state_q == S_DECODE && decoded == CL_ILLEGAL)
            illegal_q <= 1'b1;
    end

    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    // Next-state and datapath control decode
    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REG;
        ALUop    = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BOFF;
                Reg2Loc = (decoded == CL_STUR) || (decoded == CL_CBZ);
                case (decoded)
                    CL_RTYPE, CL_ORRI, CL_LDUR, CL_STUR: state_d = S_EXEC;
                    CL_CBZ, CL_B:                        state_d = S_BRCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:                             state_d = S_HALT;
`else
                    default:                             state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (class_q)
                    CL_RTYPE: begin
                        ALUSrcB = SRCB_REG;
                        ALUop   = ALUOP_FUNC;
                        state_d = S_WBACK;
                    end
                    CL_ORRI: begin
                        ALUSrcB = SRCB_IMM;
                        ALUop   = ALUOP_FUNC;
                        state_d = S_WBACK;
                    end
                    CL_LDUR, CL_STUR: begin
                        ALUSrcB = SRCB_IMM;
                        ALUop   = ALUOP_ADD;
                        state_d = S_MEMACC;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMACC: begin
                MemRead  = (class_q == CL_LDUR);
                MemWrite = (class_q == CL_STUR);
                if (MemReady)
                    state_d = (class_q == CL_LDUR) ? S_WBACK : S_FETCH;
            end
            S_WBACK: begin
                RegWrite = 1'b1;
                MemtoReg = (class_q == CL_LDUR);
                state_d  = S_FETCH;
            end
            S_BRCH: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                ALUop   = ALUOP_PASSB;
                Reg2Loc = 1'b1;
                PCSrc   = 1'b1;
                PCWrite = (class_q == CL_B) || ((class_q == CL_CBZ) && Zero);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Reset kills every write strobe in the same cycle it is asserted
        if (!Reset_L) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector scoreboard bench for the control
// sequencer. The driver applies one cycle of inputs and queues the expected
// output vector; a monitor pops and compares on each falling edge.
// Honors CTRL_ILLEGAL_TRAP_EN for the unrecognized-opcode sequence.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [10:0] Opcode;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite;
    logic        MemtoReg, Reg2Loc, ALUSrcA, Illegal;
    logic [1:0]  ALUSrcB, ALUop;
    logic [2:0]  State;

    multicycle_control dut (
        .CLK      (CLK),
        .Reset_L  (Reset_L),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .MemReady (MemReady),
        .PCWrite  (PCWrite),
        .PCSrc    (PCSrc),
        .IRWrite  (IRWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .MemtoReg (MemtoReg),
        .Reg2Loc  (Reg2Loc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUop    (ALUop),
        .State    (State),
        .Illegal  (Illegal)
    );

    always #5 CLK = ~CLK;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] ORRI = 11'b10110010001;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] BR   = 11'b00010111111;
    localparam logic [10:0] BAD  = 11'h7FF;

    // Strobe field order: PCWrite PCSrc IRWrite MemRead MemWrite RegWrite MemtoReg Reg2Loc ALUSrcA
    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [16:0] act;
    assign act = {PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg,
                  Reg2Loc, ALUSrcA, ALUSrcB, ALUop, State, Illegal};

    function automatic logic [16:0] ev(input logic [2:0] st, input logic [8:0] s,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic ill);
        return {s, asb, aop, st, ill};
    endfunction

    task automatic cyc(input string name, input logic rl, input logic [10:0] op,
                       input logic z, input logic mr, input logic [16:0] e);
        exp_t x;
        @(posedge CLK);
        #1;
        Reset_L  = rl;
        Opcode   = op;
        Zero     = z;
        MemReady = mr;
        x.v    = e;
        x.name = name;
        sbq.push_back(x);
    endtask

    // Monitor: one comparison per queued expectation, sampled mid-cycle
    initial begin
        forever begin
            exp_t x;
            @(negedge CLK);
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                n_tests++;
                if (act !== x.v) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b (strobes|asb|aop|state|ill)",
                             x.name, act, x.v);
                end
            end
        end
    end

    initial begin
        Reset_L  = 1'b0;
        Opcode   = ADD;
        Zero     = 1'b0;
        MemReady = 1'b1;

        // Reset state
        cyc("rst0", 0, ADD, 0, 1, ev(0, 9'b000000000, 2'b01, 2'b00, 0));
        cyc("rst1", 0, ADD, 0, 1, ev(0, 9'b000000000, 2'b01, 2'b00, 0));

        // ADD; IR changes after DECODE must not matter
        cyc("add_f", 1, ADD,  0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("add_d", 1, ADD,  0, 1, ev(1, 9'b000000000, 2'b11, 2'b00, 0));
        cyc("add_e", 1, LDUR, 0, 1, ev(2, 9'b000000001, 2'b00, 2'b10, 0));
        cyc("add_w", 1, LDUR, 0, 1, ev(4, 9'b000001000, 2'b00, 2'b00, 0));

        // LDUR with two MEMACC stall cycles
        cyc("ld_f",  1, LDUR, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("ld_d",  1, LDUR, 0, 1, ev(1, 9'b000000000, 2'b11, 2'b00, 0));
        cyc("ld_e",  1, ADD,  0, 1, ev(2, 9'b000000001, 2'b10, 2'b00, 0));
        cyc("ld_m0", 1, ADD,  0, 0, ev(3, 9'b000100000, 2'b00, 2'b00, 0));
        cyc("ld_m1", 1, ADD,  0, 0, ev(3, 9'b000100000, 2'b00, 2'b00, 0));
        cyc("ld_m2", 1, ADD,  0, 1, ev(3, 9'b000100000, 2'b00, 2'b00, 0));
        cyc("ld_w",  1, ADD,  0, 1, ev(4, 9'b000001100, 2'b00, 2'b00, 0));

        // STUR, no stalls
        cyc("st_f", 1, STUR, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("st_d", 1, STUR, 0, 1, ev(1, 9'b000000010, 2'b11, 2'b00, 0));
        cyc("st_e", 1, STUR, 0, 1, ev(2, 9'b000000001, 2'b10, 2'b00, 0));
        cyc("st_m", 1, STUR, 0, 1, ev(3, 9'b000010000, 2'b00, 2'b00, 0));

        // STUR abandoned by reset during MEMACC
        cyc("sr_f",   1, STUR, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("sr_d",   1, STUR, 0, 1, ev(1, 9'b000000010, 2'b11, 2'b00, 0));
        cyc("sr_e",   1, STUR, 0, 1, ev(2, 9'b000000001, 2'b10, 2'b00, 0));
        cyc("sr_m",   1, STUR, 0, 0, ev(3, 9'b000010000, 2'b00, 2'b00, 0));
        cyc("sr_rst", 0, STUR, 0, 0, ev(3, 9'b000000000, 2'b00, 2'b00, 0));
        cyc("sr_aft", 0, STUR, 0, 0, ev(0, 9'b000000000, 2'b01, 2'b00, 0));

        // ORRI; MemReady low outside FETCH/MEMACC is ignored
        cyc("or_f", 1, ORRI, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("or_d", 1, ORRI, 0, 0, ev(1, 9'b000000000, 2'b11, 2'b00, 0));
        cyc("or_e", 1, ORRI, 0, 0, ev(2, 9'b000000001, 2'b10, 2'b10, 0));
        cyc("or_w", 1, ORRI, 0, 0, ev(4, 9'b000001000, 2'b00, 2'b00, 0));

        // FETCH stall of three cycles, then CBZ taken
        cyc("cz_s0", 1, CBZ, 0, 0, ev(0, 9'b000100000, 2'b01, 2'b00, 0));
        cyc("cz_s1", 1, CBZ, 0, 0, ev(0, 9'b000100000, 2'b01, 2'b00, 0));
        cyc("cz_s2", 1, CBZ, 0, 0, ev(0, 9'b000100000, 2'b01, 2'b00, 0));
        cyc("cz_f",  1, CBZ, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("cz_d",  1, CBZ, 0, 1, ev(1, 9'b000000010, 2'b11, 2'b00, 0));
        cyc("cz_b",  1, CBZ, 1, 1, ev(5, 9'b110000011, 2'b00, 2'b01, 0));

        // CBZ not taken (Zero high earlier must not matter)
        cyc("cn_f", 1, CBZ, 1, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("cn_d", 1, CBZ, 1, 1, ev(1, 9'b000000010, 2'b11, 2'b00, 0));
        cyc("cn_b", 1, CBZ, 0, 1, ev(5, 9'b010000011, 2'b00, 2'b01, 0));

        // Unconditional B with Zero low
        cyc("b_f", 1, BR, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("b_d", 1, BR, 0, 1, ev(1, 9'b000000000, 2'b11, 2'b00, 0));
        cyc("b_b", 1, BR, 0, 1, ev(5, 9'b110000011, 2'b00, 2'b01, 0));

        // Unrecognized opcode
        cyc("il_f", 1, BAD, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("il_d", 1, BAD, 0, 1, ev(1, 9'b000000000, 2'b11, 2'b00, 0));
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc("il_h0",  1, ADD, 0, 1, ev(6, 9'b000000000, 2'b00, 2'b00, 1));
        cyc("il_h1",  1, ADD, 1, 1, ev(6, 9'b000000000, 2'b00, 2'b00, 1));
        cyc("il_h2",  1, ADD, 0, 0, ev(6, 9'b000000000, 2'b00, 2'b00, 1));
        cyc("il_rst", 0, ADD, 0, 1, ev(6, 9'b000000000, 2'b00, 2'b00, 1));
        cyc("il_aft", 0, ADD, 0, 1, ev(0, 9'b000000000, 2'b01, 2'b00, 0));
        cyc("il_f2",  1, ADD, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
`else
        cyc("il_n0", 1, ADD, 0, 0, ev(0, 9'b000100000, 2'b01, 2'b00, 0));
        cyc("il_n1", 1, ADD, 0, 0, ev(0, 9'b000100000, 2'b01, 2'b00, 0));
        cyc("il_n2", 1, ADD, 0, 1, ev(0, 9'b101100000, 2'b01, 2'b00, 0));
        cyc("il_n3", 1, ADD, 0, 1, ev(1, 9'b000000000, 2'b11, 2'b00, 0));
`endif

        @(negedge CLK);
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
